// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file write-port arbiter: FSM state,
// buffered side-unit entry and the datapath width.
package rf_wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef enum logic {
        ARB   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic [AW-1:0]   waddr;
        logic [XLEN-1:0] res;
    } side_entry_t;

    // x0 is hardwired zero, so a write to it must never reach the register file.
    function automatic logic wr_allowed(input logic [AW-1:0] waddr);
        return waddr != '0;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small circular FIFO buffering side-unit results; head is visible
// combinationally so the arbiter can pop it in the same cycle it grants.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  side_entry_t              i_wr_entry,
    input  logic                     i_pop,
    output side_entry_t              o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    side_entry_t      mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign o_full  = count_reg == (PTR_W+1)'(DEPTH);
    assign o_empty = count_reg == '0;
    assign o_count = count_reg;
    assign o_head  = mem[rd_ptr_reg];
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    // Storage carries no reset; validity is tracked purely by the count.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= i_wr_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file write-port arbiter: pipeline writeback has priority, side
// results queue in a FIFO and are force-drained once the head starves.
module rf_wb_arb
    import rf_wb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_pipe_vld,
    input  logic            i_pipe_rd_wen,
    input  logic [4:0]      i_pipe_rd_waddr,
    input  logic [XLEN-1:0] i_pipe_res,
    output logic            o_pipe_rdy,
    input  logic            i_side_vld,
    input  logic [4:0]      i_side_rd_waddr,
    input  logic [XLEN-1:0] i_side_res,
    output logic            o_side_rdy,
    output logic            o_rd_wen,
    output logic [4:0]      o_rd_waddr,
    output logic [XLEN-1:0] o_rd_wdata,
    output logic            o_vld,
    output logic            o_side_done,
    output logic            o_drain
);

    localparam int              CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state_reg;
    logic [3:0]        starve_reg;
    logic              rd_wen_reg;
    logic [4:0]        rd_waddr_reg;
    logic [XLEN-1:0]   rd_wdata_reg;
    logic              vld_reg;
    logic              side_done_reg;

    side_entry_t       side_in;
    side_entry_t       fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pipe_grant;
    logic              side_pop;
    logic              side_push;
    logic              starve_hit;

    always_comb begin
        side_in       = '0;
        side_in.waddr = i_side_rd_waddr;
        side_in.res   = i_side_res;
    end

    assign o_pipe_rdy = (state_reg == ARB) && !i_rst;
    assign o_side_rdy = !fifo_full && !i_rst;
    assign side_push  = i_side_vld && o_side_rdy;
    assign pipe_grant = o_pipe_rdy && i_pipe_vld;
    // In ARB the FIFO only gets the port when the pipeline leaves it idle.
    assign side_pop   = !i_rst && !fifo_empty && ((state_reg == DRAIN) || !i_pipe_vld);
    assign starve_hit = (starve_reg == STARVE_LIM) || fifo_full;
    assign o_drain    = state_reg == DRAIN;

    assign o_rd_wen    = rd_wen_reg;
    assign o_rd_waddr  = rd_waddr_reg;
    assign o_rd_wdata  = rd_wdata_reg;
    assign o_vld       = vld_reg;
    assign o_side_done = side_done_reg;

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (side_push),
        .i_wr_entry (side_in),
        .i_pop      (side_pop),
        .o_head     (fifo_head),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty),
        .o_count    (fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= ARB;
            starve_reg    <= '0;
            rd_wen_reg    <= 1'b0;
            rd_waddr_reg  <= '0;
            rd_wdata_reg  <= '0;
            vld_reg       <= 1'b0;
            side_done_reg <= 1'b0;
        end else begin
            vld_reg       <= pipe_grant;
            side_done_reg <= side_pop;

            if (pipe_grant) begin
                rd_wen_reg   <= i_pipe_rd_wen && wr_allowed(i_pipe_rd_waddr);
                rd_waddr_reg <= i_pipe_rd_waddr;
                rd_wdata_reg <= i_pipe_res;
            end else if (side_pop) begin
                rd_wen_reg   <= wr_allowed(fifo_head.waddr);
                rd_waddr_reg <= fifo_head.waddr;
                rd_wdata_reg <= fifo_head.res;
            end else begin
                rd_wen_reg   <= 1'b0;
            end

            // Saturate rather than wrap so a large STARVE_MAX cannot alias.
            if (side_pop || fifo_empty) begin
                starve_reg <= '0;
            end else if ((state_reg == ARB) && (starve_reg != 4'hF)) begin
                starve_reg <= starve_reg + 4'd1;
            end

            case (state_reg)
                ARB: begin
                    if (!fifo_empty && !side_pop && starve_hit) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A push landing with the last pop keeps the drain going.
                    if (fifo_empty || (side_pop && (fifo_count == CNT_ONE) && !side_push)) begin
                        state_reg <= ARB;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb: table-driven pipeline vectors, a
// queue scoreboard on every retire/side_done pulse, and timed corner sequences.
module tb_rf_wb_arb;
    import rf_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_vld = 1'b0;
    logic        pipe_wen = 1'b0;
    logic [4:0]  pipe_waddr = '0;
    logic [31:0] pipe_res = '0;
    logic        side_vld = 1'b0;
    logic [4:0]  side_waddr = '0;
    logic [31:0] side_res = '0;
    logic        pipe_rdy, side_rdy, rd_wen, vld, side_done, drain;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;

    always #5 clk = ~clk;

    rf_wb_arb #(
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pipe_vld      (pipe_vld),
        .i_pipe_rd_wen   (pipe_wen),
        .i_pipe_rd_waddr (pipe_waddr),
        .i_pipe_res      (pipe_res),
        .o_pipe_rdy      (pipe_rdy),
        .i_side_vld      (side_vld),
        .i_side_rd_waddr (side_waddr),
        .i_side_res      (side_res),
        .o_side_rdy      (side_rdy),
        .o_rd_wen        (rd_wen),
        .o_rd_waddr      (rd_waddr),
        .o_rd_wdata      (rd_wdata),
        .o_vld           (vld),
        .o_side_done     (side_done),
        .o_drain         (drain)
    );

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] res;
        logic        exp_wen;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    exp_t pq[$];
    exp_t sq[$];
    exp_t mon_e;
    exp_t push_e;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: check the pulse launched at the last edge, then record what
    // the upcoming edge will accept.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("one_grant", {31'd0, vld & side_done}, 32'd0);
            if (vld) begin
                chk("pipe_q_has_entry", {31'd0, pq.size() != 0}, 32'd1);
                if (pq.size() != 0) begin
                    mon_e = pq.pop_front();
                    chk("sb_pipe_wen", {31'd0, rd_wen}, {31'd0, mon_e.wen});
                    if (mon_e.wen) begin
                        chk("sb_pipe_waddr", {27'd0, rd_waddr}, {27'd0, mon_e.waddr});
                        chk("sb_pipe_wdata", rd_wdata, mon_e.data);
                    end
                    $display("pipe retire: wen=%0d x%0d=0x%08h", rd_wen, rd_waddr, rd_wdata);
                end
            end else if (side_done) begin
                chk("side_q_has_entry", {31'd0, sq.size() != 0}, 32'd1);
                if (sq.size() != 0) begin
                    mon_e = sq.pop_front();
                    chk("sb_side_wen", {31'd0, rd_wen}, {31'd0, mon_e.wen});
                    if (mon_e.wen) begin
                        chk("sb_side_waddr", {27'd0, rd_waddr}, {27'd0, mon_e.waddr});
                        chk("sb_side_wdata", rd_wdata, mon_e.data);
                    end
                    $display("side write:  wen=%0d x%0d=0x%08h", rd_wen, rd_waddr, rd_wdata);
                end
            end else begin
                chk("idle_wen", {31'd0, rd_wen}, 32'd0);
            end

            if (rst) begin
                pq.delete();
                sq.delete();
            end else begin
                if (pipe_vld && pipe_rdy) begin
                    push_e.wen   = pipe_wen && (pipe_waddr != 5'd0);
                    push_e.waddr = pipe_waddr;
                    push_e.data  = pipe_res;
                    pq.push_back(push_e);
                end
                if (side_vld && side_rdy) begin
                    push_e.wen   = side_waddr != 5'd0;
                    push_e.waddr = side_waddr;
                    push_e.data  = side_res;
                    sq.push_back(push_e);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'h00001111, 1'b0, 5'd0,  32'h0};
        vecs[2] = '{1'b0, 5'd9,  32'h00002222, 1'b0, 5'd0,  32'h0};
        vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
        vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};
        vecs[5] = '{1'b1, 5'd17, 32'hA5A5A5A5, 1'b1, 5'd17, 32'hA5A5A5A5};

        // Reset state
        step();
        step();
        chk("rst_rd_wen", {31'd0, rd_wen}, 32'd0);
        chk("rst_rd_waddr", {27'd0, rd_waddr}, 32'd0);
        chk("rst_rd_wdata", rd_wdata, 32'd0);
        chk("rst_vld", {31'd0, vld}, 32'd0);
        chk("rst_side_done", {31'd0, side_done}, 32'd0);
        chk("rst_drain", {31'd0, drain}, 32'd0);
        chk("rst_side_rdy", {31'd0, side_rdy}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        step();
        chk("post_rst_side_rdy", {31'd0, side_rdy}, 32'd1);
        chk("post_rst_pipe_rdy", {31'd0, pipe_rdy}, 32'd1);
        chk("post_rst_wen", {31'd0, rd_wen}, 32'd0);

        // Back-to-back pipeline vectors, one cycle latency each
        for (int i = 0; i < 6; i++) begin
            pipe_vld   = 1'b1;
            pipe_wen   = vecs[i].wen;
            pipe_waddr = vecs[i].waddr;
            pipe_res   = vecs[i].res;
            step();
            $display("vec %0d: wen=%0d x%0d res=0x%08h -> rd_wen=%0d", i, vecs[i].wen, vecs[i].waddr, vecs[i].res, rd_wen);
            chk("vec_vld", {31'd0, vld}, 32'd1);
            chk("vec_wen", {31'd0, rd_wen}, {31'd0, vecs[i].exp_wen});
            if (vecs[i].exp_wen) begin
                chk("vec_waddr", {27'd0, rd_waddr}, {27'd0, vecs[i].exp_waddr});
                chk("vec_wdata", rd_wdata, vecs[i].exp_wdata);
            end
        end
        pipe_vld = 1'b0;
        step();
        chk("vec_idle_vld", {31'd0, vld}, 32'd0);

        // Single side result with the pipeline idle: write two cycles later
        side_vld = 1'b1; side_waddr = 5'd7; side_res = 32'h12;
        chk("side_rdy_empty", {31'd0, side_rdy}, 32'd1);
        step();
        side_vld = 1'b0;
        chk("side_not_yet", {31'd0, side_done}, 32'd0);
        step();
        chk("side_done", {31'd0, side_done}, 32'd1);
        chk("side_wen", {31'd0, rd_wen}, 32'd1);
        chk("side_waddr", {27'd0, rd_waddr}, 32'd7);
        chk("side_wdata", rd_wdata, 32'h12);
        step();
        chk("side_done_pulse", {31'd0, side_done}, 32'd0);

        // Starvation: pipeline busy, one side entry forced out after STARVE_MAX
        pipe_vld = 1'b1; pipe_wen = 1'b1; pipe_waddr = 5'd20; pipe_res = $urandom;
        side_vld = 1'b1; side_waddr = 5'd3; side_res = 32'hCAFE;
        step();
        side_vld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("starve_drain_lo", {31'd0, drain}, 32'd0);
            chk("starve_prdy_hi", {31'd0, pipe_rdy}, 32'd1);
            pipe_res = $urandom; pipe_waddr = 5'(k + 20);
            step();
        end
        chk("starve_drain_hi", {31'd0, drain}, 32'd1);
        chk("starve_prdy_lo", {31'd0, pipe_rdy}, 32'd0);
        pipe_res = 32'h0BAD0005; pipe_waddr = 5'd25;
        step();
        chk("starve_side_done", {31'd0, side_done}, 32'd1);
        chk("starve_no_vld", {31'd0, vld}, 32'd0);
        chk("starve_waddr", {27'd0, rd_waddr}, 32'd3);
        chk("starve_wdata", rd_wdata, 32'hCAFE);
        chk("starve_back_arb", {31'd0, drain}, 32'd0);
        chk("starve_prdy_back", {31'd0, pipe_rdy}, 32'd1);
        step();
        pipe_vld = 1'b0;
        step();

        // Full FIFO: drain in order; a push beside the last pop extends drain
        pipe_vld = 1'b1; pipe_res = $urandom; pipe_waddr = 5'd8;
        side_vld = 1'b1; side_waddr = 5'd10; side_res = 32'hAAAA;
        step();
        chk("full_rdy_one", {31'd0, side_rdy}, 32'd1);
        side_waddr = 5'd11; side_res = 32'hBBBB; pipe_res = $urandom;
        step();
        side_waddr = 5'd12; side_res = 32'hCCCC; pipe_res = $urandom;
        chk("full_rdy_lo", {31'd0, side_rdy}, 32'd0);
        chk("full_not_drain", {31'd0, drain}, 32'd0);
        step();
        chk("full_drain", {31'd0, drain}, 32'd1);
        chk("full_prdy_lo", {31'd0, pipe_rdy}, 32'd0);
        chk("full_rdy_still_lo", {31'd0, side_rdy}, 32'd0);
        pipe_res = 32'h0BAD0006;
        step();
        chk("full_a_done", {31'd0, side_done}, 32'd1);
        chk("full_a_waddr", {27'd0, rd_waddr}, 32'd10);
        chk("full_a_wdata", rd_wdata, 32'hAAAA);
        chk("full_rdy_after_pop", {31'd0, side_rdy}, 32'd1);
        step();
        side_vld = 1'b0;
        chk("full_b_waddr", {27'd0, rd_waddr}, 32'd11);
        chk("full_b_wdata", rd_wdata, 32'hBBBB);
        chk("full_drain_ext", {31'd0, drain}, 32'd1);
        step();
        chk("full_c_done", {31'd0, side_done}, 32'd1);
        chk("full_c_waddr", {27'd0, rd_waddr}, 32'd12);
        chk("full_c_wdata", rd_wdata, 32'hCCCC);
        chk("full_back_arb", {31'd0, drain}, 32'd0);
        step();
        pipe_vld = 1'b0;
        step();

        // x0 destinations: pulses without a write
        pipe_vld = 1'b1; pipe_wen = 1'b1; pipe_waddr = 5'd0; pipe_res = 32'h55;
        side_vld = 1'b1; side_waddr = 5'd0; side_res = 32'h66;
        step();
        chk("x0_pipe_vld", {31'd0, vld}, 32'd1);
        chk("x0_pipe_wen", {31'd0, rd_wen}, 32'd0);
        pipe_vld = 1'b0; side_vld = 1'b0;
        step();
        chk("x0_side_done", {31'd0, side_done}, 32'd1);
        chk("x0_side_wen", {31'd0, rd_wen}, 32'd0);
        step();

        // Reset while draining two entries
        pipe_vld = 1'b1; pipe_waddr = 5'd4; pipe_res = $urandom;
        side_vld = 1'b1; side_waddr = 5'd1; side_res = 32'h101;
        step();
        side_waddr = 5'd2; side_res = 32'h202;
        step();
        side_vld = 1'b0;
        step();
        chk("rst_mid_drain", {31'd0, drain}, 32'd1);
        rst = 1'b1; pipe_vld = 1'b0;
        step();
        chk("rst_mid_wen", {31'd0, rd_wen}, 32'd0);
        chk("rst_mid_waddr", {27'd0, rd_waddr}, 32'd0);
        chk("rst_mid_wdata", rd_wdata, 32'd0);
        chk("rst_mid_vld", {31'd0, vld}, 32'd0);
        chk("rst_mid_side_done", {31'd0, side_done}, 32'd0);
        chk("rst_mid_drain_lo", {31'd0, drain}, 32'd0);
        chk("rst_mid_side_rdy_lo", {31'd0, side_rdy}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_mid_side_rdy_hi", {31'd0, side_rdy}, 32'd1);
        step();
        chk("rst_no_stale_wen", {31'd0, rd_wen}, 32'd0);
        chk("rst_no_stale_done", {31'd0, side_done}, 32'd0);
        step();
        chk("rst_no_stale_done2", {31'd0, side_done}, 32'd0);
        step();

        chk("pipe_q_drained", pq.size(), 32'd0);
        chk("side_q_drained", sq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
